// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable data/parity/stop framing,
// 2-of-3 majority bit sampling and parity, framing and line-break reporting.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int UART_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_data_in,
    output logic                 byte_rxed,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);
    localparam int DIV = (CLK_FREQ + UART_RATE * OVERSAMPLE / 2) / (UART_RATE * OVERSAMPLE);
    localparam int DW  = $clog2(DIV + 1);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [SW-1:0] S_LO      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI      = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    D_LAST    = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, RX_START_BIT, RX_DATA_BITS, RX_PARITY_BIT, RX_STOP_BIT, CLEANUP
    } state_t;

    state_t                 state;
    logic                   sync1, sync2, rx_d;
    logic [DW-1:0]          div_cnt;
    logic [SW-1:0]          s_cnt;
    logic [1:0]             samp;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit, stop0, stop_low;
    logic                   start_edge, tick, mid, bit_end, vote, first_stop;

    // mid fires on the last of the three centre samples, when the vote is complete
    always_comb begin
        start_edge = (state == IDLE) && rx_d && !sync2;
        tick       = div_cnt == DIV_LAST;
        mid        = tick && s_cnt == S_HI;
        bit_end    = tick && s_cnt == S_LAST;
        vote       = (samp[1] & samp[0]) | (samp[1] & sync2) | (samp[0] & sync2);
        first_stop = (bit_cnt == 4'd0) ? vote : stop0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_d    <= 1'b1;
            div_cnt <= '0;
            samp    <= '0;
        end else begin
            sync1   <= uart_data_in;
            sync2   <= sync1;
            rx_d    <= sync2;
            div_cnt <= (start_edge || tick) ? '0 : div_cnt + 1'b1;
            if (tick && (s_cnt == S_LO || s_cnt == S_MID))
                samp <= {samp[0], sync2};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            s_cnt      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            stop0      <= 1'b0;
            stop_low   <= 1'b0;
            byte_rxed  <= 1'b0;
            rx_byte    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            byte_rxed <= 1'b0;
            s_cnt     <= (state == IDLE) ? '0 : tick ? ((s_cnt == S_LAST) ? '0 : s_cnt + 1'b1) : s_cnt;
            case (state)
                IDLE: begin
                    busy <= start_edge;
                    if (start_edge)
                        state <= RX_START_BIT;
                end
                RX_START_BIT: begin
                    if (mid && vote) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bit_end) begin
                        state   <= RX_DATA_BITS;
                        bit_cnt <= '0;
                    end
                end
                RX_DATA_BITS: begin
                    if (mid)
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                    if (bit_end) begin
                        bit_cnt  <= (bit_cnt == D_LAST) ? 4'd0 : bit_cnt + 1'b1;
                        stop_low <= 1'b0;
                        if (bit_cnt == D_LAST)
                            state <= (PARITY == 0) ? RX_STOP_BIT : RX_PARITY_BIT;
                    end
                end
                RX_PARITY_BIT: begin
                    if (mid)
                        par_bit <= vote;
                    if (bit_end)
                        state <= RX_STOP_BIT;
                end
                RX_STOP_BIT: begin
                    if (mid && bit_cnt == STOP_LAST) begin
                        state      <= CLEANUP;
                        byte_rxed  <= 1'b1;
                        rx_byte    <= shreg;
                        parity_err <= (PARITY != 0) && ((^shreg ^ par_bit) != (PARITY == 1));
                        frame_err  <= stop_low | ~vote;
                        break_det  <= (shreg == '0) && (PARITY == 0 || !par_bit) && !first_stop;
                    end else if (mid) begin
                        stop0    <= vote;
                        stop_low <= ~vote;
                    end else if (bit_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                // a held break stays here until the line recovers, giving one pulse only
                CLEANUP: begin
                    if (sync2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames on a default-config receiver plus randomized
// even-parity/two-stop frames on a second instance, checked against a rule-level model.
module tb_uart_rx_cfg;
    localparam int BIT_A = 864;
    localparam int BIT_B = 56;

    logic       clk = 1'b0, rst = 1'b1, line_a = 1'b1, line_b = 1'b1;
    logic       a_rxed, a_pe, a_fe, a_bd, a_busy;
    logic       b_rxed, b_pe, b_fe, b_bd, b_busy;
    logic [7:0] a_byte, b_byte;
    int         n_cmp = 0, n_bad = 0, pulses_a = 0, pulses_b = 0;
    logic [7:0] got_a[$];
    logic [7:0] cap_a_byte = 8'h00, cap_b_byte = 8'h00;
    logic [2:0] cap_a = 3'b000, cap_b = 3'b000;

    uart_rx_cfg dut_a (
        .clk(clk), .rst(rst), .uart_data_in(line_a), .byte_rxed(a_rxed), .rx_byte(a_byte),
        .parity_err(a_pe), .frame_err(a_fe), .break_det(a_bd), .busy(a_busy)
    );

    uart_rx_cfg #(.UART_RATE(1_875_000), .OVERSAMPLE(8), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .uart_data_in(line_b), .byte_rxed(b_rxed), .rx_byte(b_byte),
        .parity_err(b_pe), .frame_err(b_fe), .break_det(b_bd), .busy(b_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_rxed) begin
            pulses_a++;
            got_a.push_back(a_byte);
            cap_a_byte = a_byte;
            cap_a = {a_pe, a_fe, a_bd};
        end
        if (b_rxed) begin
            pulses_b++;
            cap_b_byte = b_byte;
            cap_b = {b_pe, b_fe, b_bd};
        end
    end

    task automatic hold_a(input logic v, input int n);
        line_a = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_b(input logic v, input int n);
        line_b = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic head_a(input logic [7:0] d);
        hold_a(1'b0, BIT_A);
        for (int i = 0; i < 8; i++) hold_a(d[i], BIT_A);
    endtask

    task automatic send_a(input logic [7:0] d);
        head_a(d);
        hold_a(1'b1, BIT_A);
    endtask

    task automatic send_b(input logic [7:0] d, input logic par, input logic [1:0] stops);
        hold_b(1'b0, BIT_B);
        for (int i = 0; i < 8; i++) hold_b(d[i], BIT_B);
        hold_b(par, BIT_B);
        hold_b(stops[0], BIT_B);
        hold_b(stops[1], BIT_B);
        hold_b(1'b1, BIT_B);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        line_a = 1'b1;
        line_b = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({a_rxed, a_byte, a_pe, a_fe, a_bd, a_busy} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_a: got %h want 0", {a_rxed, a_byte, a_pe, a_fe, a_bd, a_busy});
        end
        n_cmp++;
        if ({b_rxed, b_byte, b_pe, b_fe, b_bd, b_busy} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_b: got %h want 0", {b_rxed, b_byte, b_pe, b_fe, b_bd, b_busy});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({a_busy, b_busy} !== 2'b00 || pulses_a + pulses_b != 0) begin
            n_bad++;
            $display("FAIL reset_idle: busy %b pulses %0d want 00 and 0", {a_busy, b_busy}, pulses_a + pulses_b);
        end
    endtask

    task automatic test_basic();
        int p;
        p = pulses_a;
        head_a(8'h55);
        hold_a(1'b1, 600);
        n_cmp++;
        if (pulses_a != p + 1) begin
            n_bad++;
            $display("FAIL stop_mid_pulse: got %0d pulses want %0d", pulses_a - p, 1);
        end
        hold_a(1'b1, BIT_A - 600);
        n_cmp++;
        if (pulses_a != p + 1 || cap_a_byte !== 8'h55 || a_byte !== 8'h55) begin
            n_bad++;
            $display("FAIL basic_data: pulses %0d byte %h/%h want 1 and 55", pulses_a - p, cap_a_byte, a_byte);
        end
        n_cmp++;
        if (cap_a !== 3'b000 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_flags: flags %b busy %b want 000 0", cap_a, a_busy);
        end
    endtask

    task automatic test_stop_err();
        int p;
        p = pulses_a;
        head_a(8'h3C);
        hold_a(1'b0, BIT_A);
        hold_a(1'b1, BIT_A);
        n_cmp++;
        if (pulses_a != p + 1 || cap_a_byte !== 8'h3C || cap_a !== 3'b010) begin
            n_bad++;
            $display("FAIL stop_err: pulses %0d byte %h pe/fe/bd %b want 1 3c 010", pulses_a - p, cap_a_byte, cap_a);
        end
    endtask

    task automatic test_break();
        int p;
        p = pulses_a;
        hold_a(1'b0, 20 * BIT_A);
        hold_a(1'b1, BIT_A);
        n_cmp++;
        if (pulses_a != p + 1 || cap_a_byte !== 8'h00 || cap_a !== 3'b011) begin
            n_bad++;
            $display("FAIL break: pulses %0d byte %h pe/fe/bd %b want 1 00 011", pulses_a - p, cap_a_byte, cap_a);
        end
        n_cmp++;
        if (a_busy !== 1'b0 || a_bd !== 1'b1) begin
            n_bad++;
            $display("FAIL break_hold: busy %b break_det %b want 0 1", a_busy, a_bd);
        end
        send_a(8'h81);
        n_cmp++;
        if (pulses_a != p + 2 || cap_a_byte !== 8'h81 || cap_a !== 3'b000) begin
            n_bad++;
            $display("FAIL after_break: pulses %0d byte %h flags %b want 2 81 000", pulses_a - p, cap_a_byte, cap_a);
        end
    endtask

    task automatic test_glitch();
        int p;
        p = pulses_a;
        hold_a(1'b0, 400);
        n_cmp++;
        if (a_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_busy: got %b want 1", a_busy);
        end
        hold_a(1'b1, BIT_A - 400);
        n_cmp++;
        if (a_busy !== 1'b0 || pulses_a != p || a_byte !== 8'h81) begin
            n_bad++;
            $display("FAIL glitch: busy %b pulses %0d byte %h want 0 0 81", a_busy, pulses_a - p, a_byte);
        end
    endtask

    task automatic test_back_to_back();
        int         p;
        logic [7:0] d3;
        got_a.delete();
        p = pulses_a;
        send_a(8'h12);
        send_a(8'h34);
        n_cmp++;
        if (got_a.size() != 2 || got_a[0] !== 8'h12 || got_a[1] !== 8'h34) begin
            n_bad++;
            $display("FAIL b2b_data: got %0d frames first %h want 2 frames 12 34", got_a.size(), cap_a_byte);
        end
        p = pulses_a;
        d3 = 8'h56;
        hold_a(1'b0, BIT_A);
        for (int i = 0; i < 4; i++) hold_a(d3[i], BIT_A);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_rxed, a_byte, a_pe, a_fe, a_bd, a_busy} !== 13'd0) begin
            n_bad++;
            $display("FAIL midframe_reset: got %h want 0", {a_rxed, a_byte, a_pe, a_fe, a_bd, a_busy});
        end
        line_a = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold_a(1'b1, 2 * BIT_A);
        n_cmp++;
        if (pulses_a != p || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL aborted_frame: pulses %0d busy %b want 0 0", pulses_a - p, a_busy);
        end
        send_a(8'h9E);
        n_cmp++;
        if (pulses_a != p + 1 || cap_a_byte !== 8'h9E || cap_a !== 3'b000) begin
            n_bad++;
            $display("FAIL post_reset_frame: pulses %0d byte %h flags %b want 1 9e 000", pulses_a - p, cap_a_byte, cap_a);
        end
    endtask

    task automatic test_parity();
        int p;
        p = pulses_b;
        send_b(8'hA7, 1'b1, 2'b11);
        n_cmp++;
        if (pulses_b != p + 1 || cap_b_byte !== 8'hA7 || cap_b !== 3'b000) begin
            n_bad++;
            $display("FAIL parity_good: pulses %0d byte %h flags %b want 1 a7 000", pulses_b - p, cap_b_byte, cap_b);
        end
        send_b(8'hA7, 1'b0, 2'b11);
        n_cmp++;
        if (pulses_b != p + 2 || cap_b_byte !== 8'hA7 || cap_b !== 3'b100) begin
            n_bad++;
            $display("FAIL parity_bad: pulses %0d byte %h flags %b want 2 a7 100", pulses_b - p, cap_b_byte, cap_b);
        end
    endtask

    task automatic test_random();
        int         p, ones;
        logic [7:0] d;
        logic       par, exp_pe, exp_fe, exp_bd;
        logic [1:0] stops;
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            par = 1'($urandom_range(0, 1));
            stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            if ($urandom_range(0, 4) == 0) begin
                d = 8'h00;
                par = 1'b0;
                stops = 2'($urandom_range(0, 3));
            end
            ones = $countones(d) + int'(par);
            exp_pe = (ones % 2) != 0;
            exp_fe = stops != 2'b11;
            exp_bd = (d == 8'h00) && !par && !stops[0];
            p = pulses_b;
            send_b(d, par, stops);
            hold_b(1'b1, BIT_B);
            n_cmp++;
            if (pulses_b != p + 1 || cap_b_byte !== d || cap_b !== {exp_pe, exp_fe, exp_bd} || b_byte !== d) begin
                n_bad++;
                $display("FAIL random_%0d: pulses %0d byte %h flags %b want 1 %h %b",
                         k, pulses_b - p, cap_b_byte, cap_b, d, {exp_pe, exp_fe, exp_bd});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stop_err();
        test_break();
        test_glitch();
        test_back_to_back();
        test_parity();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
